// File: rtl/dct_da_pkg.sv
// Shared constants, coefficient table and LUT helper for the bit-serial DA DCT engine.
package dct_da_pkg;

    localparam int unsigned N_TAPS = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned LUT_W  = COEF_W + $clog2(N_TAPS);
    localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS);

    // Q2.14 cosine constants, ck = round(cos(k*pi/16) * 2^14)
    localparam int C1 = 16069;
    localparam int C2 = 15137;
    localparam int C3 = 13623;
    localparam int C4 = 11585;
    localparam int C5 = 9102;
    localparam int C6 = 6270;
    localparam int C7 = 3196;

    localparam int COEF [8][4] = '{
        '{C4,  C4,  C4,  C4},
        '{C1,  C3,  C5,  C7},
        '{C2,  C6, -C6, -C2},
        '{C3, -C7, -C1, -C5},
        '{C4, -C4, -C4,  C4},
        '{C5, -C1,  C7,  C3},
        '{C6, -C2,  C2, -C6},
        '{C7, -C5,  C3, -C1}
    };

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    // Sum of the row coefficients whose tap bit is set; tap 0 maps to the address MSB.
    function automatic int lut_entry(input logic [2:0] row, input logic [7:0] addr,
                                     input int ntaps);
        int sum;
        int idx;
        sum = 0;
        for (int n = 0; n < 4; n++) begin
            idx = ntaps - 1 - n;
            if (n < ntaps && idx >= 0) begin
                if (addr[idx[2:0]]) sum += COEF[row][n];
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/da_lut.sv
// Combinational DA lookup: partial coefficient sum for one bit slice of the tap vector.
module da_lut
    import dct_da_pkg::*;
#(
    parameter int unsigned N_TAPS = dct_da_pkg::N_TAPS,
    parameter int unsigned COEF_W = dct_da_pkg::COEF_W,
    parameter int unsigned LUT_W  = COEF_W + $clog2(N_TAPS)
) (
    input  logic [2:0]              row_sel,
    input  logic [N_TAPS-1:0]       addr,
    output logic signed [LUT_W-1:0] psum
);

    logic [7:0] addr_ext;
    int         sum;

    always_comb begin
        addr_ext = 8'(addr);
        sum      = lut_entry(row_sel, addr_ext, int'(N_TAPS));
        psum     = LUT_W'(sum);
    end

endmodule

// File: rtl/da_dct_engine.sv
// Bit-serial distributed-arithmetic MAC producing one DCT coefficient per accepted vector.
module da_dct_engine
    import dct_da_pkg::*;
#(
    parameter int unsigned N_TAPS = dct_da_pkg::N_TAPS,
    parameter int unsigned DATA_W = dct_da_pkg::DATA_W,
    parameter int unsigned COEF_W = dct_da_pkg::COEF_W,
    parameter int unsigned ACC_W  = DATA_W + COEF_W + $clog2(N_TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_TAPS*DATA_W-1:0] x_in,
    input  logic [2:0]               row_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         y_out,
    output logic                     busy
);

    localparam int unsigned LUT_W = COEF_W + $clog2(N_TAPS);
    localparam int unsigned CW    = $clog2(DATA_W);

    state_t                   state_q;
    logic [DATA_W-1:0]        x_q [N_TAPS];
    logic [2:0]               row_q;
    logic [CW-1:0]            bit_cnt_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  y_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;

    logic [N_TAPS-1:0]        addr;
    logic signed [LUT_W-1:0]  psum;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_d;
    logic                     last;

    da_lut #(
        .N_TAPS (N_TAPS),
        .COEF_W (COEF_W),
        .LUT_W  (LUT_W)
    ) u_lut (
        .row_sel (row_q),
        .addr    (addr),
        .psum    (psum)
    );

    // The sign slice carries negative weight, so it is subtracted instead of added.
    always_comb begin
        addr = '0;
        for (int n = 0; n < int'(N_TAPS); n++) begin
            addr[N_TAPS-1-n] = x_q[n][0];
        end
        term  = {{(ACC_W-LUT_W){psum[LUT_W-1]}}, psum} <<< bit_cnt_q;
        last  = (bit_cnt_q == CW'(DATA_W - 1));
        acc_d = last ? (acc_q - term) : (acc_q + term);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            bit_cnt_q   <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int n = 0; n < int'(N_TAPS); n++) x_q[n] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int n = 0; n < int'(N_TAPS); n++) begin
                            x_q[n] <= x_in[n*DATA_W +: DATA_W];
                        end
                        row_q      <= row_sel;
                        acc_q      <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= ACC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ACC: begin
                    acc_q     <= acc_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    for (int n = 0; n < int'(N_TAPS); n++) x_q[n] <= x_q[n] >> 1;
                    if (last) begin
                        y_q         <= acc_d;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y_out     = y_q;

endmodule

// File: tb/tb_da_dct_engine.sv
// Scoreboard bench for da_dct_engine: directed vectors plus a randomised dot-product sweep.
module tb_da_dct_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] x_in = '0;
    logic [2:0]  row_sel = '0;
    logic        in_ready;
    logic        out_valid;
    logic [33:0] y_out;
    logic        busy;

    da_dct_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .row_sel   (row_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    localparam int K1 = 16069, K2 = 15137, K3 = 13623, K4 = 11585;
    localparam int K5 = 9102,  K6 = 6270,  K7 = 3196;
    localparam int TB_COEF [8][4] = '{
        '{K4,  K4,  K4,  K4}, '{K1,  K3,  K5,  K7},
        '{K2,  K6, -K6, -K2}, '{K3, -K7, -K1, -K5},
        '{K4, -K4, -K4,  K4}, '{K5, -K1,  K7,  K3},
        '{K6, -K2,  K2, -K6}, '{K7, -K5,  K3, -K1}
    };

    int      checks = 0;
    int      errors = 0;
    longint  exp_q[$];
    int      cyc = 0;
    int      acc_cyc = 0;
    bit      pending = 1'b0;
    bit      rand_mode = 1'b0;
    int      xfers = 0;
    logic    ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rand_mode) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic longint ref_dot(input int row, input int a, input int b,
                                       input int c, input int d);
        return longint'(TB_COEF[row][0]) * a + longint'(TB_COEF[row][1]) * b +
               longint'(TB_COEF[row][2]) * c + longint'(TB_COEF[row][3]) * d;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: latency on every out_valid rise, scoreboard pop on every handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev && pending) begin
                check("latency", longint'(cyc - acc_cyc), 64'sd16);
                pending = 1'b0;
            end
            if (in_valid && in_ready) begin
                pending = 1'b1;
                acc_cyc = cyc + 1;
            end
            if (out_valid && out_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none",
                             longint'($signed(y_out)));
                end else begin
                    check("y_out", longint'($signed(y_out)), exp_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    // All tasks start and end at posedge+1.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic send(input int row, input int a, input int b, input int c, input int d,
                        input longint expv);
        wait_ready();
        x_in     = {16'(d), 16'(c), 16'(b), 16'(a)};
        row_sel  = 3'(row);
        in_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in     = {$urandom, $urandom};
        row_sel  = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid || busy) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", longint'(exp_q.size()), 0);
    endtask

    initial begin
        longint e;
        int     base;
        int     n;
        int     r;
        int     xs [4];

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", longint'(in_ready), 1);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_busy", longint'(busy), 0);
        check("reset_y_out", longint'(y_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 1, 1, 1, 1, 46340);
        wait_idle();
        send(6, 0, 0, 0, 1, -6270);
        send(2, 1, 0, 0, 0, 15137);
        send(0, -32768, -32768, -32768, -32768, -1518469120);
        send(4, -1, 0, 0, 0, -11585);
        wait_idle();

        // Back-pressure with ignored input pulses while DONE.
        out_ready = 1'b0;
        e = ref_dot(1, 100, -200, 300, -400);
        send(1, 100, -200, 300, -400, e);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_out_valid", longint'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            x_in     = {16'd9, 16'd9, 16'd9, 16'd9};
            row_sel  = 3'd0;
            @(posedge clk);
            #1;
            check("bp_y_stable", longint'($signed(y_out)), e);
            check("bp_in_ready", longint'(in_ready), 0);
            check("bp_out_valid_held", longint'(out_valid), 1);
        end
        in_valid  = 1'b0;
        base      = xfers;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_one_xfer", longint'(xfers - base), 1);
        check("bp_out_valid_drop", longint'(out_valid), 0);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_extra", longint'(xfers - base), 1);

        // Abort mid-accumulation.
        send(3, 5, 6, 7, 8, ref_dot(3, 5, 6, 7, 8));
        check("acc_busy", longint'(busy), 1);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_busy", longint'(busy), 0);
        check("abort_y_out", longint'(y_out), 0);
        exp_q.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(5, -3, 2, 1000, -7, ref_dot(5, -3, 2, 1000, -7));
        wait_idle();

        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(0, 7));
            for (int k = 0; k < 4; k++) xs[k] = int'($signed(16'($urandom)));
            send(r, xs[0], xs[1], xs[2], xs[3], ref_dot(r, xs[0], xs[1], xs[2], xs[3]));
        end
        wait_idle();
        rand_mode = 1'b0;
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
